// File: rtl/reg_file_banked_if.sv
// Register-file port bundle: write/immediate/read ports, bank save/restore controls
// and the debug dump stream.
interface reg_file_banked_if #(
    parameter int W = 8,
    parameter int A = 2
);
    logic           WriteEn;
    logic           ImmEn;
    logic           ImmHi;
    logic [W/2-1:0] ImmVal;
    logic [A-1:0]   Waddr;
    logic [W-1:0]   DataIn;
    logic [A-1:0]   RaddrA;
    logic [A-1:0]   RaddrB;
    logic [A-1:0]   RaddrC;
    logic           Shift;
    logic [W-1:0]   DataOutA;
    logic [W-1:0]   DataOutB;
    logic [W-1:0]   DataOutC;
    logic           SaveReq;
    logic           RestoreReq;
    logic           DumpStart;
    logic           DumpReady;
    logic           DumpValid;
    logic [A-1:0]   DumpAddr;
    logic [W-1:0]   DumpData;
    logic           DumpBusy;
    logic           DumpDone;

    modport master (
        output WriteEn, ImmEn, ImmHi, ImmVal, Waddr, DataIn,
        output RaddrA, RaddrB, RaddrC, Shift,
        output SaveReq, RestoreReq, DumpStart, DumpReady,
        input  DataOutA, DataOutB, DataOutC,
        input  DumpValid, DumpAddr, DumpData, DumpBusy, DumpDone
    );

    modport slave (
        input  WriteEn, ImmEn, ImmHi, ImmVal, Waddr, DataIn,
        input  RaddrA, RaddrB, RaddrC, Shift,
        input  SaveReq, RestoreReq, DumpStart, DumpReady,
        output DataOutA, DataOutB, DataOutC,
        output DumpValid, DumpAddr, DumpData, DumpBusy, DumpDone
    );
endinterface

// File: rtl/reg_file_banked.sv
// Banked register file: 2**A x W primary bank, single-cycle shadow bank, half-word insert, debug dump.
// Latency: reads combinational (same-cycle forwarding when BYPASS=1); writes commit on the Clk edge.
// Backpressure: a dump beat holds address and snapshot data while DumpReady is low.
module reg_file_banked #(
    parameter int W      = 8,
    parameter int A      = 2,
    parameter int BYPASS = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    reg_file_banked_if.slave bus
);
    localparam int           N    = 1 << A;
    localparam logic [A-1:0] LAST = A'(N - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [W-1:0] prim [N];
    logic [W-1:0] shad [N];

    logic         wr_acc;
    logic [W-1:0] wr_old;
    logic [W-1:0] wr_val;

    // Restore owns the whole primary bank for the cycle, so it drops any write.
    assign wr_acc = (bus.ImmEn || bus.WriteEn) && !bus.RestoreReq;
    assign wr_old = prim[bus.Waddr];

    always_comb begin
        wr_val = bus.DataIn;
        if (bus.ImmEn) begin
            wr_val = wr_old;
            if (bus.ImmHi) begin
                wr_val[W-1:W/2] = bus.ImmVal;
            end else begin
                wr_val[W/2-1:0] = bus.ImmVal;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                prim[i] <= '0;
                shad[i] <= '0;
            end
        end else begin
            // Both sides sample pre-edge contents, so Save+Restore is a clean swap.
            for (int i = 0; i < N; i++) begin
                if (bus.SaveReq) begin
                    shad[i] <= prim[i];
                end
                if (bus.RestoreReq) begin
                    prim[i] <= shad[i];
                end
            end
            if (wr_acc) begin
                prim[bus.Waddr] <= wr_val;
            end
        end
    end

    logic [A-1:0]   sel_a;
    logic [2*A-1:0] addr_pair;
    logic [W-1:0]   shift_imm;
    logic           byp_a;
    logic           byp_b;
    logic           byp_c;

    assign sel_a     = bus.Shift ? bus.RaddrC : bus.RaddrA;
    assign addr_pair = {bus.RaddrA, bus.RaddrB};

    if (2 * A >= W) begin : g_pair_trunc
        assign shift_imm = addr_pair[W-1:0];
    end else begin : g_pair_ext
        assign shift_imm = {{(W - 2 * A){1'b0}}, addr_pair};
    end

    assign byp_a = (BYPASS != 0) && wr_acc && (sel_a == bus.Waddr);
    assign byp_b = (BYPASS != 0) && wr_acc && !bus.Shift && (bus.RaddrB == bus.Waddr);
    assign byp_c = (BYPASS != 0) && wr_acc && (bus.RaddrC == bus.Waddr);

    assign bus.DataOutA = byp_a ? wr_val : prim[sel_a];
    assign bus.DataOutB = bus.Shift ? shift_imm : (byp_b ? wr_val : prim[bus.RaddrB]);
    assign bus.DataOutC = byp_c ? wr_val : prim[bus.RaddrC];

    state_t       state;
    logic         dump_vld;
    logic         dump_busy;
    logic         dump_done;
    logic [A-1:0] dump_addr;
    logic [A-1:0] dump_addr_nxt;
    logic [W-1:0] dump_dat;

    assign dump_addr_nxt = dump_addr + 1'b1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            dump_vld  <= 1'b0;
            dump_busy <= 1'b0;
            dump_done <= 1'b0;
            dump_addr <= '0;
            dump_dat  <= '0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.DumpStart) begin
                        state     <= SEND;
                        dump_vld  <= 1'b1;
                        dump_busy <= 1'b1;
                        dump_addr <= '0;
                        dump_dat  <= prim[0];
                    end
                end
                SEND: begin
                    if (dump_vld && bus.DumpReady) begin
                        if (dump_addr == LAST) begin
                            state     <= IDLE;
                            dump_vld  <= 1'b0;
                            dump_busy <= 1'b0;
                            dump_done <= 1'b1;
                        end else begin
                            dump_addr <= dump_addr_nxt;
                            dump_dat  <= prim[dump_addr_nxt];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.DumpValid = dump_vld;
    assign bus.DumpBusy  = dump_busy;
    assign bus.DumpDone  = dump_done;
    assign bus.DumpAddr  = dump_addr;
    assign bus.DumpData  = dump_dat;
endmodule

// File: tb/tb_reg_file_banked.sv
// Bench for reg_file_banked: a forwarding instance and a non-forwarding instance share stimulus;
// read and dump expectations are queued when driven and popped when the outputs are sampled.
module tb_reg_file_banked;
    localparam int W = 8;
    localparam int A = 2;

    logic Clk;
    logic Reset;

    reg_file_banked_if #(.W(W), .A(A)) bus ();
    reg_file_banked_if #(.W(W), .A(A)) bus0 ();

    reg_file_banked #(.W(W), .A(A), .BYPASS(1)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    reg_file_banked #(.W(W), .A(A), .BYPASS(0)) dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));

    assign bus0.WriteEn    = bus.WriteEn;
    assign bus0.ImmEn      = bus.ImmEn;
    assign bus0.ImmHi      = bus.ImmHi;
    assign bus0.ImmVal     = bus.ImmVal;
    assign bus0.Waddr      = bus.Waddr;
    assign bus0.DataIn     = bus.DataIn;
    assign bus0.RaddrA     = bus.RaddrA;
    assign bus0.RaddrB     = bus.RaddrB;
    assign bus0.RaddrC     = bus.RaddrC;
    assign bus0.Shift      = bus.Shift;
    assign bus0.SaveReq    = bus.SaveReq;
    assign bus0.RestoreReq = bus.RestoreReq;
    assign bus0.DumpStart  = bus.DumpStart;
    assign bus0.DumpReady  = bus.DumpReady;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        int         port;
        logic [7:0] v;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] dq[$];
    logic [7:0] m[4];
    int         checks = 0;
    int         errors = 0;

    // Ports 0..2 are A/B/C of the forwarding instance, 3..5 the non-forwarding one.
    function automatic logic [7:0] obs(input int p);
        case (p)
            0: return bus.DataOutA;
            1: return bus.DataOutB;
            2: return bus.DataOutC;
            3: return bus0.DataOutA;
            4: return bus0.DataOutB;
            default: return bus0.DataOutC;
        endcase
    endfunction

    task automatic exp_rd(input string n, input int p, input logic [7:0] v);
        exp_t e;
        e.name = n;
        e.port = p;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.WriteEn = 0; bus.ImmEn = 0; bus.ImmHi = 0; bus.ImmVal = '0;
        bus.Waddr = '0; bus.DataIn = '0; bus.RaddrA = '0; bus.RaddrB = '0;
        bus.RaddrC = '0; bus.Shift = 0; bus.SaveReq = 0; bus.RestoreReq = 0;
        bus.DumpStart = 0; bus.DumpReady = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [7:0] got;
        Reset = 1'b1;
        idle();
        repeat (2) @(posedge Clk);
        for (int st = 0; st < 2; st++) begin
            @(negedge Clk);
            Reset = 1'b0;
            idle();
            if (st == 0) begin
                bus.RaddrA = 2'd0; bus.RaddrB = 2'd1; bus.RaddrC = 2'd2;
            end else begin
                bus.RaddrA = 2'd3;
            end
            for (int p = 0; p < 6; p++) exp_rd("reset_regs", p, 8'h00);
            #1;
            if (st == 0) begin
                checks++;
                if ({bus.DumpValid, bus.DumpBusy, bus.DumpDone, bus.DumpAddr, bus.DumpData} !== 13'd0) begin
                    errors++;
                    $display("FAIL reset_dump got %b exp 0", {bus.DumpValid, bus.DumpBusy, bus.DumpDone, bus.DumpAddr, bus.DumpData});
                end
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = obs(e.port);
                checks++;
                if (got !== e.v) begin errors++; $display("FAIL %s port%0d got %h exp %h", e.name, e.port, got, e.v); end
            end
        end
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
    endtask

    task automatic test_write_bypass();
        exp_t e;
        logic [7:0] got;
        for (int st = 0; st < 2; st++) begin
            @(negedge Clk);
            idle();
            bus.RaddrA = 2'd2;
            if (st == 0) begin
                bus.WriteEn = 1; bus.Waddr = 2'd2; bus.DataIn = 8'hA5;
                exp_rd("wr_byp_a", 0, 8'hA5);
                exp_rd("wr_nobyp_a", 3, 8'h00);
                exp_rd("wr_other_c", 2, 8'h00);
            end else begin
                exp_rd("wr_next_a", 0, 8'hA5);
                exp_rd("wr_next_nobyp_a", 3, 8'hA5);
            end
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = obs(e.port);
                checks++;
                if (got !== e.v) begin errors++; $display("FAIL %s port%0d got %h exp %h", e.name, e.port, got, e.v); end
            end
        end
        m[2] = 8'hA5;
    endtask

    task automatic test_imm();
        exp_t e;
        logic [7:0] got;
        for (int st = 0; st < 4; st++) begin
            @(negedge Clk);
            idle();
            bus.RaddrB = 2'd1;
            bus.Waddr  = 2'd1;
            case (st)
                0: begin
                    bus.WriteEn = 1; bus.DataIn = 8'h3C;
                    exp_rd("imm_load_b", 1, 8'h3C); exp_rd("imm_load_nobyp_b", 4, 8'h00);
                end
                1: begin
                    bus.WriteEn = 1; bus.DataIn = 8'hFF; bus.ImmEn = 1; bus.ImmHi = 1; bus.ImmVal = 4'h9;
                    exp_rd("imm_hi_byp_b", 1, 8'h9C); exp_rd("imm_hi_nobyp_b", 4, 8'h3C);
                end
                2: begin
                    bus.ImmEn = 1; bus.ImmHi = 0; bus.ImmVal = 4'h5;
                    exp_rd("imm_lo_byp_b", 1, 8'h95); exp_rd("imm_hi_result_b", 4, 8'h9C);
                end
                default: begin
                    exp_rd("imm_lo_result_b", 1, 8'h95); exp_rd("imm_lo_result_nobyp_b", 4, 8'h95);
                end
            endcase
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = obs(e.port);
                checks++;
                if (got !== e.v) begin errors++; $display("FAIL %s port%0d got %h exp %h", e.name, e.port, got, e.v); end
            end
        end
        m[1] = 8'h95;
    endtask

    task automatic test_shift();
        exp_t e;
        logic [7:0] got;
        for (int st = 0; st < 4; st++) begin
            @(negedge Clk);
            idle();
            case (st)
                0: begin
                    bus.WriteEn = 1; bus.Waddr = 2'd0; bus.DataIn = 8'h11;
                    exp_rd("sh_load_c", 2, 8'h11); exp_rd("sh_load_nobyp_c", 5, 8'h00);
                end
                1: begin
                    bus.Shift = 1; bus.RaddrA = 2'b10; bus.RaddrB = 2'b11; bus.RaddrC = 2'd0;
                    exp_rd("sh_a", 0, 8'h11); exp_rd("sh_b", 1, 8'h0B); exp_rd("sh_c", 2, 8'h11);
                    exp_rd("sh_nobyp_a", 3, 8'h11); exp_rd("sh_nobyp_b", 4, 8'h0B);
                end
                2: begin
                    bus.Shift = 1; bus.RaddrA = 2'd1; bus.RaddrB = 2'd0; bus.RaddrC = 2'd3;
                    bus.WriteEn = 1; bus.Waddr = 2'd3; bus.DataIn = 8'h77;
                    exp_rd("sh_byp_a", 0, 8'h77); exp_rd("sh_imm_nobyp_b", 1, 8'h04); exp_rd("sh_byp_c", 2, 8'h77);
                    exp_rd("sh_wr_nobyp_a", 3, 8'h00); exp_rd("sh_wr_nobyp_b", 4, 8'h04); exp_rd("sh_wr_nobyp_c", 5, 8'h00);
                end
                default: begin
                    bus.RaddrA = 2'd2; bus.RaddrB = 2'd3; bus.RaddrC = 2'd0;
                    for (int p = 0; p < 6; p++)
                        exp_rd("noshift_abc", p, (p % 3 == 0) ? 8'hA5 : ((p % 3 == 1) ? 8'h77 : 8'h11));
                end
            endcase
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = obs(e.port);
                checks++;
                if (got !== e.v) begin errors++; $display("FAIL %s port%0d got %h exp %h", e.name, e.port, got, e.v); end
            end
        end
        m[0] = 8'h11;
        m[3] = 8'h77;
    endtask

    task automatic test_bank();
        exp_t e;
        logic [7:0] got;
        for (int st = 0; st < 14; st++) begin
            @(negedge Clk);
            idle();
            case (st)
                0, 1, 2, 3: begin
                    bus.WriteEn = 1; bus.Waddr = 2'(st); bus.DataIn = 8'(st + 1); bus.RaddrC = 2'(st);
                    exp_rd("bank_load_c", 2, 8'(st + 1));
                end
                4: begin
                    bus.SaveReq = 1;
                    exp_rd("bank_save_a", 0, 8'h01);
                end
                5: begin
                    bus.WriteEn = 1; bus.Waddr = 2'd0; bus.DataIn = 8'h55;
                    exp_rd("bank_w55_a", 0, 8'h55); exp_rd("bank_w55_nobyp_a", 3, 8'h01);
                end
                6: begin
                    bus.SaveReq = 1; bus.RestoreReq = 1;
                    exp_rd("bank_swap_pre_a", 0, 8'h55); exp_rd("bank_swap_pre_nobyp_a", 3, 8'h55);
                end
                7: begin
                    bus.RaddrA = 2'd0; bus.RaddrB = 2'd1; bus.RaddrC = 2'd2;
                    for (int p = 0; p < 6; p++) exp_rd("bank_swap_prim", p, 8'(p % 3 + 1));
                end
                8: begin
                    bus.RestoreReq = 1; bus.WriteEn = 1; bus.Waddr = 2'd1; bus.DataIn = 8'hEE;
                    bus.RaddrA = 2'd3; bus.RaddrB = 2'd1;
                    exp_rd("bank_rs_a", 0, 8'h04); exp_rd("bank_rs_nofwd_b", 1, 8'h02);
                    exp_rd("bank_rs_nobyp_a", 3, 8'h04); exp_rd("bank_rs_nobyp_b", 4, 8'h02);
                end
                9: begin
                    bus.RaddrA = 2'd0; bus.RaddrB = 2'd1; bus.RaddrC = 2'd2;
                    for (int p = 0; p < 6; p++)
                        exp_rd("bank_swap_shadow", p, (p % 3 == 0) ? 8'h55 : 8'(p % 3 + 1));
                end
                10: begin
                    bus.SaveReq = 1; bus.WriteEn = 1; bus.Waddr = 2'd2; bus.DataIn = 8'h66; bus.RaddrC = 2'd2;
                    exp_rd("bank_svwr_c", 2, 8'h66); exp_rd("bank_svwr_nobyp_c", 5, 8'h03);
                end
                11: begin
                    bus.RaddrC = 2'd2; bus.RaddrA = 2'd3;
                    exp_rd("bank_svwr_prim_c", 2, 8'h66); exp_rd("bank_svwr_prim_nobyp_c", 5, 8'h66);
                    exp_rd("bank_r3_a", 0, 8'h04);
                end
                12: begin
                    bus.RestoreReq = 1; bus.RaddrC = 2'd2;
                    exp_rd("bank_rs2_pre_c", 2, 8'h66); exp_rd("bank_rs2_pre_nobyp_c", 5, 8'h66);
                end
                default: begin
                    bus.RaddrC = 2'd2;
                    exp_rd("bank_svwr_shadow_c", 2, 8'h03); exp_rd("bank_svwr_shadow_nobyp_c", 5, 8'h03);
                end
            endcase
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = obs(e.port);
                checks++;
                if (got !== e.v) begin errors++; $display("FAIL %s port%0d got %h exp %h", e.name, e.port, got, e.v); end
            end
        end
        m[0] = 8'h55; m[1] = 8'h02; m[2] = 8'h03; m[3] = 8'h04;
    endtask

    task automatic test_dump();
        logic [5:0] pat;
        int k, hs_last, done_cyc, done_cnt;
        pat = 6'b101101;  // ready per valid cycle, LSB first: 1,0,1,1,0,1
        k = 0; hs_last = -1; done_cyc = -1; done_cnt = 0;
        @(negedge Clk);
        idle();
        bus.DumpStart = 1'b1;
        for (int i = 0; i < 4; i++) dq.push_back({2'(i), m[i]});
        #1;
        checks++;
        if (bus.DumpValid !== 1'b0 || bus.DumpBusy !== 1'b0) begin
            errors++; $display("FAIL dump_start_cycle got vld %b busy %b exp 0 0", bus.DumpValid, bus.DumpBusy);
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge Clk);
            idle();
            bus.DumpStart = (cyc >= 2 && cyc <= 4);
            bus.DumpReady = (k < 6) ? pat[k] : 1'b1;
            if (bus.DumpValid && !bus.DumpReady && bus.DumpAddr == 2'd1) begin
                bus.WriteEn = 1; bus.Waddr = 2'd1; bus.DataIn = 8'hEE; m[1] = 8'hEE;
            end
            #1;
            if (bus.DumpDone) begin done_cnt++; done_cyc = cyc; end
            if (bus.DumpValid) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++; $display("FAIL dump_extra_beat got addr %0d data %h exp none", bus.DumpAddr, bus.DumpData);
                end else begin
                    if ({bus.DumpAddr, bus.DumpData} !== dq[0]) begin
                        errors++; $display("FAIL dump_beat got %0d:%h exp %0d:%h", bus.DumpAddr, bus.DumpData, dq[0][9:8], dq[0][7:0]);
                    end
                    if (bus.DumpReady) void'(dq.pop_front());
                end
                if (bus.DumpReady) hs_last = cyc;
                k++;
            end
        end
        checks++;
        if (dq.size() != 0) begin errors++; $display("FAIL dump_missing_beats got %0d left exp 0", dq.size()); end
        dq.delete();
        checks++;
        if (done_cnt != 1 || done_cyc != hs_last + 1) begin
            errors++; $display("FAIL dump_done got %0d pulses at cyc %0d exp 1 at cyc %0d", done_cnt, done_cyc, hs_last + 1);
        end
        @(negedge Clk);
        idle();
        bus.RaddrA = 2'd1;
        #1;
        checks++;
        if (bus.DataOutA !== 8'hEE || bus.DumpBusy !== 1'b0) begin
            errors++; $display("FAIL dump_write_during got r1 %h busy %b exp ee 0", bus.DataOutA, bus.DumpBusy);
        end
    endtask

    task automatic test_back_to_back();
        logic got_done;
        int   cyc_n;
        int   dcnt;
        @(negedge Clk);
        idle();
        bus.DumpReady = 1; bus.DumpStart = 1;
        for (int i = 0; i < 4; i++) dq.push_back({2'(i), m[i]});
        got_done = 0; cyc_n = 0;
        while (!got_done && cyc_n < 20) begin
            @(negedge Clk);
            idle();
            bus.DumpReady = 1;
            cyc_n++;
            #1;
            if (bus.DumpValid) begin
                checks++;
                if (dq.size() == 0 || {bus.DumpAddr, bus.DumpData} !== dq[0]) begin
                    errors++; $display("FAIL b2b_beat got %0d:%h exp %0d queued", bus.DumpAddr, bus.DumpData, dq.size());
                end
                if (dq.size() != 0) void'(dq.pop_front());
            end
            if (bus.DumpDone) got_done = 1;
        end
        checks++;
        if (!got_done || cyc_n != 5) begin
            errors++; $display("FAIL dump_latency got done %b after %0d cycles exp 1 after 5", got_done, cyc_n);
        end
        // Still inside the DumpDone cycle: this start must be accepted.
        bus.DumpStart = 1;
        dq.delete();
        for (int i = 0; i < 4; i++) dq.push_back({2'(i), m[i]});
        cyc_n = 0;
        while (cyc_n < 20) begin
            @(negedge Clk);
            idle();
            bus.DumpReady = 1;
            cyc_n++;
            #1;
            if (bus.DumpValid && bus.DumpAddr == 2'd2) break;
            checks++;
            if (!bus.DumpValid || dq.size() == 0 || {bus.DumpAddr, bus.DumpData} !== dq[0]) begin
                errors++; $display("FAIL restart_beat got vld %b %0d:%h exp valid beat from 0", bus.DumpValid, bus.DumpAddr, bus.DumpData);
            end
            if (dq.size() != 0) void'(dq.pop_front());
        end
        checks++;
        if (cyc_n != 3) begin errors++; $display("FAIL restart_reach_beat2 got cycle %0d exp 3", cyc_n); end
        Reset = 1'b1;
        dq.delete();
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        @(negedge Clk);
        Reset = 1'b0;
        idle();
        #1;
        checks++;
        if ({bus.DumpValid, bus.DumpBusy, bus.DumpDone} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_dump got vld/busy/done %b exp 000", {bus.DumpValid, bus.DumpBusy, bus.DumpDone});
        end
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            #1;
            if (bus.DumpDone) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin errors++; $display("FAIL reset_no_done got %0d pulses exp 0", dcnt); end
        @(negedge Clk);
        idle(); bus.WriteEn = 1; bus.Waddr = 2'd0; bus.DataIn = 8'h5A; m[0] = 8'h5A;
        @(negedge Clk);
        idle(); bus.WriteEn = 1; bus.Waddr = 2'd3; bus.DataIn = 8'hC3; m[3] = 8'hC3;
        @(negedge Clk);
        idle(); bus.DumpStart = 1; bus.DumpReady = 1;
        for (int i = 0; i < 4; i++) dq.push_back({2'(i), m[i]});
        got_done = 0; cyc_n = 0;
        while (!got_done && cyc_n < 20) begin
            @(negedge Clk);
            idle();
            bus.DumpReady = 1;
            cyc_n++;
            #1;
            if (bus.DumpValid) begin
                checks++;
                if (dq.size() == 0 || {bus.DumpAddr, bus.DumpData} !== dq[0]) begin
                    errors++; $display("FAIL post_reset_beat got %0d:%h exp %0d queued", bus.DumpAddr, bus.DumpData, dq.size());
                end
                if (dq.size() != 0) void'(dq.pop_front());
            end
            if (bus.DumpDone) got_done = 1;
        end
        checks++;
        if (!got_done || dq.size() != 0) begin
            errors++; $display("FAIL post_reset_dump got done %b left %0d exp 1 0", got_done, dq.size());
        end
        dq.delete();
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        test_reset();
        test_write_bypass();
        test_imm();
        test_shift();
        test_bank();
        test_dump();
        test_back_to_back();
        @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end
endmodule
